// File: rtl/color_gen_pkg.sv
// rtl/color_gen_pkg.sv - shared types, mode codes and saturating add for the colour generator
package color_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        WHITE,
        SCALE,
        APPLY
    } state_e;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4,
        S5,
        SRED
    } sector_e;

    localparam logic [7:0] MODE_DIRECT_DEF = 8'h21;
    localparam logic [7:0] MODE_HUE_DEF    = 8'hA4;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

endpackage

// File: rtl/color_gen_param_scaler.sv
// rtl/color_gen_param_scaler.sv - four-lane shift-add scaler, c_out = (c * (lint + 1)) >> DW
module color_scaler #(
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DW-1:0]        lint,
    input  logic [3:0][DW-1:0]   c_in,
    output logic [3:0][DW-1:0]   c_out,
    output logic                 done
);

    localparam int unsigned CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [2*DW-1:0] prod_q  [4];
    logic [2*DW-1:0] prod_d  [4];
    logic [2*DW-1:0] mcand_q [4];
    logic [2*DW-1:0] mcand_d [4];
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;

    // The product is seeded with c itself so that only lint's DW bits need walking.
    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            for (int i = 0; i < 4; i++) begin
                prod_d[i]  = {{DW{1'b0}}, c_in[i]};
                mcand_d[i] = {{DW{1'b0}}, c_in[i]};
            end
            mplier_d = lint;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mplier_q[0]) begin
                    prod_d[i] = prod_q[i] + mcand_q[i];
                end
                mcand_d[i] = mcand_q[i] << 1;
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i]  <= '0;
                mcand_q[i] <= '0;
            end
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            c_out[i] = prod_q[i][2*DW-1:DW];
        end
    end

    assign done = done_q;

endmodule

// File: rtl/color_gen_param.sv
// rtl/color_gen_param.sv - hue/white/intensity to RGBW generator with direct pass-through mode
module color_gen_param
    import color_gen_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned STEP        = 7,
    parameter int unsigned SECTOR_LEN  = 36,
    parameter logic [7:0]  MODE_DIRECT = MODE_DIRECT_DEF,
    parameter logic [7:0]  MODE_HUE    = MODE_HUE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    mode,
    input  logic          start,
    input  logic [DW-1:0] hue,
    input  logic [DW-1:0] lint,
    input  logic [DW-1:0] white_in,
    input  logic [DW-1:0] red_in,
    input  logic [DW-1:0] green_in,
    input  logic [DW-1:0] blue_in,
    output logic [DW-1:0] red_out,
    output logic [DW-1:0] green_out,
    output logic [DW-1:0] blue_out,
    output logic [DW-1:0] white_out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   MAXV     = (2 ** DW) - 1;
    localparam logic [DW-1:0] MAX_C    = DW'(MAXV);
    localparam logic [DW:0]   ITER_LIM = (DW + 1)'(6 * SECTOR_LEN);
    localparam logic [DW-1:0] POS_LIM  = DW'(SECTOR_LEN);

    state_e        state_q, state_d;
    sector_e       sector_q, sector_d;
    logic [7:0]    mode_q;
    logic [DW-1:0] hue_q, hue_d, lint_q, lint_d, white_q, white_d;
    logic [DW:0]   iter_q, iter_d;
    logic [DW-1:0] pos_q, pos_d, acc_q, acc_d;
    logic [DW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d, wout_q, wout_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [DW:0]        target;
    logic [DW-1:0]      up, down, base_r, base_g, base_b, pos_next;
    logic [3:0][DW-1:0] mix, scaled;
    logic               scl_start, scl_done;

    assign target = ({1'b0, hue_q} > ITER_LIM) ? ITER_LIM : {1'b0, hue_q};
    assign up     = acc_q;
    assign down   = MAX_C - acc_q;

    always_comb begin
        base_r = MAX_C;
        base_g = '0;
        base_b = '0;
        unique case (sector_q)
            S0:      begin base_r = MAX_C; base_g = '0;    base_b = up;    end
            S1:      begin base_r = down;  base_g = '0;    base_b = MAX_C; end
            S2:      begin base_r = '0;    base_g = up;    base_b = MAX_C; end
            S3:      begin base_r = '0;    base_g = MAX_C; base_b = down;  end
            S4:      begin base_r = up;    base_g = MAX_C; base_b = '0;    end
            S5:      begin base_r = MAX_C; base_g = down;  base_b = '0;    end
            default: begin base_r = MAX_C; base_g = '0;    base_b = '0;    end
        endcase
        mix[0] = DW'(sat_add(32'(base_r), 32'(white_q), MAXV));
        mix[1] = DW'(sat_add(32'(base_g), 32'(white_q), MAXV));
        mix[2] = DW'(sat_add(32'(base_b), 32'(white_q), MAXV));
        mix[3] = white_q;
    end

    assign scl_start = (state_q == WHITE);

    color_scaler #(.DW(DW)) u_scaler (
        .clk   (clk),
        .reset (reset),
        .start (scl_start),
        .lint  (lint_q),
        .c_in  (mix),
        .c_out (scaled),
        .done  (scl_done)
    );

    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        hue_d    = hue_q;
        lint_d   = lint_q;
        white_d  = white_q;
        iter_d   = iter_q;
        pos_d    = pos_q;
        acc_d    = acc_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        wout_d   = wout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pos_next = pos_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (mode_q == MODE_DIRECT) begin
                    red_d   = red_in;
                    green_d = green_in;
                    blue_d  = blue_in;
                    wout_d  = white_in;
                end else if (mode_q == MODE_HUE && start) begin
                    hue_d    = hue;
                    lint_d   = lint;
                    white_d  = white_in;
                    iter_d   = '0;
                    pos_d    = '0;
                    acc_d    = '0;
                    sector_d = S0;
                    busy_d   = 1'b1;
                    state_d  = (hue == '0) ? WHITE : RAMP;
                end
            end
            RAMP: begin
                iter_d = iter_q + 1'b1;
                if (pos_next == POS_LIM) begin
                    pos_d = '0;
                    acc_d = '0;
                    if (sector_q != SRED) begin
                        sector_d = sector_e'(3'(sector_q) + 3'd1);
                    end
                end else begin
                    pos_d = pos_next;
                    acc_d = DW'(sat_add(32'(acc_q), STEP, MAXV));
                end
                if (iter_d == target) begin
                    state_d = WHITE;
                end
            end
            WHITE: state_d = SCALE;
            SCALE: begin
                if (scl_done) begin
                    busy_d  = 1'b0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                red_d   = scaled[0];
                green_d = scaled[1];
                blue_d  = scaled[2];
                wout_d  = scaled[3];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sector_q <= S0;
            mode_q   <= '0;
            hue_q    <= '0;
            lint_q   <= '0;
            white_q  <= '0;
            iter_q   <= '0;
            pos_q    <= '0;
            acc_q    <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            wout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            mode_q   <= mode;
            hue_q    <= hue_d;
            lint_q   <= lint_d;
            white_q  <= white_d;
            iter_q   <= iter_d;
            pos_q    <= pos_d;
            acc_q    <= acc_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            wout_q   <= wout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;
    assign white_out = wout_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
